// File: rtl/noc_flit_rx_endpoint_if.sv
// Flit-in / AXIS-out bundle for the NoC receive endpoint.
// The slave modport is the endpoint's view. The master modport is the router/sink side.
interface noc_flit_rx_endpoint_if #(
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int TDATA_WIDTH          = 128,
  parameter int SERIALIZATION_FACTOR = 1
);
  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;

  logic [FLIT_WIDTH-1:0]  data_in;
  logic [DEST_WIDTH-1:0]  dest_in;
  logic                   is_tail_in;
  logic                   send_in;
  logic                   credit_out;
  logic                   axis_out_tvalid;
  logic                   axis_out_tready;
  logic [TDATA_WIDTH-1:0] axis_out_tdata;
  logic                   axis_out_tlast;
  logic [TID_WIDTH-1:0]   axis_out_tid;
  logic [TDEST_WIDTH-1:0] axis_out_tdest;
  logic                   err_overflow;
  logic                   err_protocol;

  modport slave (
    input  data_in, dest_in, is_tail_in, send_in, axis_out_tready,
    output credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
           axis_out_tid, axis_out_tdest, err_overflow, err_protocol
  );

  modport master (
    output data_in, dest_in, is_tail_in, send_in, axis_out_tready,
    input  credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
           axis_out_tid, axis_out_tdest, err_overflow, err_protocol
  );
endinterface

// File: rtl/noc_flit_rx_endpoint.sv
// Credit-based flit receiver: flit FIFO, one credit per pop, and SF-flit to AXIS beat reassembly
// with sticky overflow and protocol error flags.
module noc_flit_rx_endpoint #(
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int TDATA_WIDTH          = 128,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_BUFFER_DEPTH    = 2
) (
  input logic                   clk_noc,
  input logic                   rst_noc,
  noc_flit_rx_endpoint_if.slave nif
);
  localparam int SF         = SERIALIZATION_FACTOR;
  localparam int DEPTH      = FLIT_BUFFER_DEPTH;
  localparam int FLIT_WIDTH = TDATA_WIDTH / SF;
  localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;
  localparam int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW         = $clog2(DEPTH + 1);
  localparam int CW         = $clog2(SF + 1);

  typedef struct packed {
    logic                  tail;
    logic [DEST_WIDTH-1:0] dest;
    logic [FLIT_WIDTH-1:0] data;
  } flit_t;

  flit_t                  mem_q [DEPTH];
  flit_t                  head;
  logic [AW-1:0]          wr_q, rd_q;
  logic [OW-1:0]          occ_q;
  logic [CW-1:0]          cnt_q, cnt_d, k;
  logic [TDATA_WIDTH-1:0] tdata_q;
  logic [DEST_WIDTH-1:0]  dest_q;
  logic                   tvalid_q, tlast_q, credit_q, err_ovf_q, err_proto_q;
  logic                   full, empty, push, pop, accept;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // Full is judged before this cycle's pop: a push into a full FIFO is always dropped.
  assign full   = (occ_q == OW'(DEPTH));
  assign empty  = (occ_q == '0);
  assign push   = nif.send_in && !full;
  assign accept = tvalid_q && nif.axis_out_tready;
  assign pop    = !empty && ((cnt_q < CW'(SF)) || accept);
  // A pop that coincides with accept lands in slot 0 of the next beat.
  assign k      = accept ? '0 : cnt_q;
  assign head   = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (accept)   cnt_d = pop ? CW'(1) : '0;
    else if (pop) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk_noc or posedge rst_noc) begin
    if (rst_noc) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      occ_q       <= '0;
      cnt_q       <= '0;
      tdata_q     <= '0;
      dest_q      <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      credit_q    <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      credit_q <= pop;
      cnt_q    <= cnt_d;
      tvalid_q <= (cnt_d == CW'(SF));
      if (push) begin
        mem_q[wr_q] <= {nif.is_tail_in, nif.dest_in, nif.data_in};
        wr_q        <= ptr_inc(wr_q);
      end
      if (pop) rd_q <= ptr_inc(rd_q);
      if (push && !pop)      occ_q <= occ_q + OW'(1);
      else if (!push && pop) occ_q <= occ_q - OW'(1);
      if (nif.send_in && full) err_ovf_q <= 1'b1;
      if (pop) begin
        for (int i = 0; i < SF; i++)
          if (k == CW'(i)) tdata_q[i*FLIT_WIDTH +: FLIT_WIDTH] <= head.data;
        // Beat dest comes from flit 0; later flits are only checked against it.
        if (k == '0)                  dest_q      <= head.dest;
        else if (head.dest != dest_q) err_proto_q <= 1'b1;
        if (k == CW'(SF - 1)) tlast_q     <= head.tail;
        else if (head.tail)   err_proto_q <= 1'b1;
      end
    end
  end

  assign nif.credit_out      = credit_q;
  assign nif.axis_out_tvalid = tvalid_q;
  assign nif.axis_out_tdata  = tdata_q;
  assign nif.axis_out_tlast  = tlast_q;
  assign nif.axis_out_tid    = dest_q[DEST_WIDTH-1 -: TID_WIDTH];
  assign nif.axis_out_tdest  = dest_q[TDEST_WIDTH-1:0];
  assign nif.err_overflow    = err_ovf_q;
  assign nif.err_protocol    = err_proto_q;
endmodule

// File: tb/tb_noc_flit_rx_endpoint.sv
// Scoreboard bench: three endpoints (SF=1/2/4, depth 2) share clock and reset; beats are
// predicted at drive time and compared as {tlast, tid, tdest, tdata} when accepted.
module tb_noc_flit_rx_endpoint;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_flit_rx_endpoint_if #(.SERIALIZATION_FACTOR(1)) if1 ();
  noc_flit_rx_endpoint_if #(.SERIALIZATION_FACTOR(2)) if2 ();
  noc_flit_rx_endpoint_if #(.SERIALIZATION_FACTOR(4)) if4 ();

  noc_flit_rx_endpoint #(.SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(2))
    u_sf1 (.clk_noc(clk), .rst_noc(rst), .nif(if1.slave));
  noc_flit_rx_endpoint #(.SERIALIZATION_FACTOR(2), .FLIT_BUFFER_DEPTH(2))
    u_sf2 (.clk_noc(clk), .rst_noc(rst), .nif(if2.slave));
  noc_flit_rx_endpoint #(.SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(2))
    u_sf4 (.clk_noc(clk), .rst_noc(rst), .nif(if4.slave));

  logic [134:0] q1[$], q2[$], q4[$];
  int           cr1, cr2, cr4;
  int           nvec, nerr;
  logic [127:0] acc2, acc4;
  logic [5:0]   dst2, dst4;
  int           k2, k4;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (if1.axis_out_tvalid && if1.axis_out_tready) begin
      if (q1.size() == 0) chk("sf1_extra_beat", 1, 0);
      else chk("sf1_beat", {if1.axis_out_tlast, if1.axis_out_tid, if1.axis_out_tdest, if1.axis_out_tdata}, q1.pop_front());
    end
    if (if2.axis_out_tvalid && if2.axis_out_tready) begin
      if (q2.size() == 0) chk("sf2_extra_beat", 1, 0);
      else chk("sf2_beat", {if2.axis_out_tlast, if2.axis_out_tid, if2.axis_out_tdest, if2.axis_out_tdata}, q2.pop_front());
    end
    if (if4.axis_out_tvalid && if4.axis_out_tready) begin
      if (q4.size() == 0) chk("sf4_extra_beat", 1, 0);
      else chk("sf4_beat", {if4.axis_out_tlast, if4.axis_out_tid, if4.axis_out_tdest, if4.axis_out_tdata}, q4.pop_front());
    end
    if (if1.credit_out) cr1++;
    if (if2.credit_out) cr2++;
    if (if4.credit_out) cr4++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] fd(input int i);
    logic [31:0] w;
    w = 32'hC0DE_0000 + 32'(i);
    return {4{w}};
  endfunction

  function automatic int qsize(input int which);
    case (which)
      1:       return q1.size();
      2:       return q2.size();
      default: return q4.size();
    endcase
  endfunction

  task automatic send1(input logic [127:0] d, input logic [5:0] dst, input logic tl, input bit keep);
    if1.send_in = 1'b1; if1.data_in = d; if1.dest_in = dst; if1.is_tail_in = tl;
    if (keep) q1.push_back({tl, dst, d});
  endtask

  task automatic send2(input logic [63:0] d, input logic [5:0] dst, input logic tl);
    if2.send_in = 1'b1; if2.data_in = d; if2.dest_in = dst; if2.is_tail_in = tl;
    acc2[k2*64 +: 64] = d;
    if (k2 == 0) dst2 = dst;
    if (k2 == 1) begin q2.push_back({tl, dst2, acc2}); k2 = 0; end
    else k2++;
  endtask

  task automatic send4(input logic [31:0] d, input logic [5:0] dst, input logic tl);
    if4.send_in = 1'b1; if4.data_in = d; if4.dest_in = dst; if4.is_tail_in = tl;
    acc4[k4*32 +: 32] = d;
    if (k4 == 0) dst4 = dst;
    if (k4 == 3) begin q4.push_back({tl, dst4, acc4}); k4 = 0; end
    else k4++;
  endtask

  task automatic idle();
    if1.send_in = 1'b0; if2.send_in = 1'b0; if4.send_in = 1'b0;
  endtask

  task automatic drain(input int which, input string tag);
    int n = 0;
    while (qsize(which) != 0 && n < 100) begin tick(); n++; end
    repeat (3) tick();
    chk(tag, qsize(which), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    cr1 = 0; cr2 = 0; cr4 = 0; k2 = 0; k4 = 0;
    q1.delete(); q2.delete(); q4.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int sent;
    nvec = 0; nerr = 0;
    cr1 = 0; cr2 = 0; cr4 = 0; k2 = 0; k4 = 0;
    acc2 = '0; acc4 = '0; dst2 = '0; dst4 = '0;
    if1.data_in = '0; if1.dest_in = '0; if1.is_tail_in = 1'b0; if1.send_in = 1'b0; if1.axis_out_tready = 1'b0;
    if2.data_in = '0; if2.dest_in = '0; if2.is_tail_in = 1'b0; if2.send_in = 1'b0; if2.axis_out_tready = 1'b0;
    if4.data_in = '0; if4.dest_in = '0; if4.is_tail_in = 1'b0; if4.send_in = 1'b0; if4.axis_out_tready = 1'b0;
    repeat (3) tick();
    chk("rst_sf1", {if1.credit_out, if1.axis_out_tvalid, if1.axis_out_tlast, if1.axis_out_tid, if1.axis_out_tdest,
                    if1.err_overflow, if1.err_protocol, if1.axis_out_tdata}, 0);
    chk("rst_sf2", {if2.credit_out, if2.axis_out_tvalid, if2.axis_out_tlast, if2.axis_out_tid, if2.axis_out_tdest,
                    if2.err_overflow, if2.err_protocol, if2.axis_out_tdata}, 0);
    chk("rst_sf4", {if4.credit_out, if4.axis_out_tvalid, if4.axis_out_tlast, if4.axis_out_tid, if4.axis_out_tdest,
                    if4.err_overflow, if4.err_protocol, if4.axis_out_tdata}, 0);
    rst = 1'b0;
    tick();

    // SF=1: 4-flit packet back-to-back, first tvalid two cycles after the first send
    if1.axis_out_tready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) send1(fd(i), 6'h15, (i == 3), 1'b1);
      else idle();
      chk("sf1_tvalid_cycle", if1.axis_out_tvalid, (i >= 2));
      tick();
    end
    idle();
    drain(1, "sf1_drain");
    chk("sf1_credits", cr1, 4);
    chk("sf1_no_err", {if1.err_overflow, if1.err_protocol}, 0);

    // SF=4: A0..A3 assemble into one beat, A0 in the low word
    if4.axis_out_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send4(32'hA0 + 32'(i), 6'h15, (i == 3));
      tick();
    end
    idle();
    drain(4, "sf4_drain");
    chk("sf4_credits", cr4, 4);

    // Backpressure on SF=1 with a credit-obeying sender
    do_reset();
    if1.axis_out_tready = 1'b0;
    sent = 0;
    for (int i = 0; i < 10; i++) begin
      if (sent < 5 && (2 + cr1 - sent) > 0) begin send1(fd(20 + sent), 6'h15, (sent == 4), 1'b1); sent++; end
      else idle();
      if (i >= 2) chk("bp_tdata_stable", if1.axis_out_tdata, fd(20));
      tick();
    end
    idle();
    chk("bp_sent", sent, 3);
    chk("bp_credits_stall", cr1, 1);
    chk("bp_no_overflow", if1.err_overflow, 0);
    if1.axis_out_tready = 1'b1;
    for (int i = 0; i < 40 && !(sent == 5 && q1.size() == 0); i++) begin
      if (sent < 5 && (2 + cr1 - sent) > 0) begin send1(fd(20 + sent), 6'h15, (sent == 4), 1'b1); sent++; end
      else idle();
      tick();
    end
    idle();
    drain(1, "bp_drain");
    chk("bp_credits_total", cr1, 5);

    // Overflow: output stage occupied, then 4 pulses ignoring credits; the last two are dropped
    do_reset();
    if1.axis_out_tready = 1'b0;
    send1(fd(99), 6'h15, 1'b0, 1'b1);
    tick();
    idle();
    repeat (3) tick();
    for (int i = 0; i < 4; i++) begin
      send1(fd(100 + i), 6'h15, (i == 3), (i < 2));
      tick();
    end
    idle();
    tick();
    chk("ovf_flag", if1.err_overflow, 1);
    chk("ovf_credits_stall", cr1, 1);
    if1.axis_out_tready = 1'b1;
    drain(1, "ovf_drain");
    chk("ovf_credits_total", cr1, 3);

    // SF=2: tail on flit 0 is a protocol error; tlast still comes from flit 1
    do_reset();
    if2.axis_out_tready = 1'b1;
    send2(64'h1111, 6'h15, 1'b1); tick();
    send2(64'h2222, 6'h15, 1'b0); tick();
    idle();
    repeat (3) tick();
    chk("proto_tail", if2.err_protocol, 1);
    drain(2, "proto_tail_drain");

    // SF=2: dest changes inside a beat; captured dest 0x05 is kept
    do_reset();
    chk("proto_cleared", if2.err_protocol, 0);
    if2.axis_out_tready = 1'b1;
    send2(64'h3333, 6'h05, 1'b0); tick();
    send2(64'h4444, 6'h06, 1'b1); tick();
    idle();
    repeat (3) tick();
    chk("proto_dest", if2.err_protocol, 1);
    drain(2, "proto_dest_drain");

    // SF=4: async reset with 2 flits in clears outputs immediately; a fresh packet follows
    do_reset();
    if4.axis_out_tready = 1'b1;
    send4(32'hDEAD_0000, 6'h2A, 1'b0); tick();
    send4(32'hDEAD_0001, 6'h2A, 1'b0); tick();
    idle();
    chk("rstmid_credit_before", if4.credit_out, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_outs", {if4.credit_out, if4.axis_out_tvalid, if4.axis_out_tlast, if4.axis_out_tid, if4.axis_out_tdest,
                        if4.err_overflow, if4.err_protocol, if4.axis_out_tdata}, 0);
    k4 = 0; cr4 = 0; q4.delete();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      send4(32'hBEEF_0000 + 32'(i), 6'h1C, (i == 3));
      tick();
    end
    idle();
    drain(4, "rstmid_drain");
    chk("rstmid_credits", cr4, 4);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
